// File: rtl/p1500_pkg.sv
// Shared types for the IEEE 1500 wrapper boundary register segment.
//   wbr_op_e    : shift-stage operation selected for the current wrck cycle
//   decode_op() : resolves the raw shift/capture/transfer pins into one op,
//                 priority shift > capture > transfer > hold. Conflicting pins
//                 are legal; priority is the only arbitration.
package p1500_pkg;

    typedef enum logic [1:0] {
        OP_HOLD     = 2'd0,
        OP_SHIFT    = 2'd1,
        OP_CAPTURE  = 2'd2,
        OP_TRANSFER = 2'd3
    } wbr_op_e;

    function automatic wbr_op_e decode_op(
        input logic shift,
        input logic capture,
        input logic transfer
    );
        wbr_op_e op;
        if (shift)
            op = OP_SHIFT;
        else if (capture)
            op = OP_CAPTURE;
        else if (transfer)
            op = OP_TRANSFER;
        else
            op = OP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/wbr_cell_sd1.sv
// One dedicated boundary cell: shift flop, update flop and functional output mux.
// Ports:
//   wrck, arst   : wrapper clock (posedge), async active-high reset
//   op_i         : decoded shift-stage operation, shared by all cells
//   update_i     : load update flop from shift flop (independent of op_i)
//   si_i / so_o  : serial chain in / out (so_o is the shift flop)
//   cfi_i/cfo_o  : functional input / output of this cell
//   io_face_i    : capture source, 1 = cfi_i, 0 = cfo_o loopback
//   mode_i       : 0 = functional passthrough, 1 = test
//   safe_i       : in test mode, drive SAFE_BIT instead of the update flop
module wbr_cell_sd1
    import p1500_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0,
    parameter logic SAFE_BIT  = 1'b0
) (
    input  logic    wrck,
    input  logic    arst,
    input  wbr_op_e op_i,
    input  logic    update_i,
    input  logic    si_i,
    output logic    so_o,
    input  logic    cfi_i,
    output logic    cfo_o,
    input  logic    io_face_i,
    input  logic    mode_i,
    input  logic    safe_i
);

    logic shift_d, shift_q;
    logic upd_d,   upd_q;

    always_comb begin
        cfo_o = cfi_i;
        if (mode_i)
            cfo_o = safe_i ? SAFE_BIT : upd_q;
    end

    always_comb begin
        shift_d = shift_q;
        case (op_i)
            OP_SHIFT:    shift_d = si_i;
            // io_face=0 samples the output actually presented, including safe
            OP_CAPTURE:  shift_d = io_face_i ? cfi_i : cfo_o;
            OP_TRANSFER: shift_d = upd_q;
            default:     shift_d = shift_q;
        endcase
    end

    // Update samples the pre-edge shift flop, so update+shift in one cycle is safe.
    always_comb begin
        upd_d = update_i ? shift_q : upd_q;
    end

    always_ff @(posedge wrck or posedge arst) begin
        if (arst) begin
            shift_q <= RESET_BIT;
            upd_q   <= RESET_BIT;
        end else begin
            shift_q <= shift_d;
            upd_q   <= upd_d;
        end
    end

    assign so_o = shift_q;

endmodule

// File: rtl/wbr_segment_sd1.sv
// Wrapper boundary register segment of WIDTH dedicated cells.
// Serial data enters cell WIDTH-1 from wsi and leaves cell 0 on wso (LSB first).
// Ports:
//   wrck, arst                : wrapper clock (posedge), async active-high reset
//   wsi / wso                 : wrapper serial in / out (wso is registered)
//   cfi / cfo                 : core functional inputs / outputs, WIDTH bits
//   shift, capture, transfer  : shift-stage controls, priority in that order
//   update                    : load update stage from shift stage
//   io_face                   : capture source, 1 = cfi, 0 = cfo loopback
//   mode                      : 0 = functional (cfo = cfi), 1 = test
//   safe                      : in test mode, force cfo = SAFE_VALUE
module wbr_segment_sd1
    import p1500_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] SAFE_VALUE  = '0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             wrck,
    input  logic             arst,
    input  logic             wsi,
    output logic             wso,
    input  logic [WIDTH-1:0] cfi,
    output logic [WIDTH-1:0] cfo,
    input  logic             shift,
    input  logic             capture,
    input  logic             transfer,
    input  logic             update,
    input  logic             io_face,
    input  logic             mode,
    input  logic             safe
);

    wbr_op_e op;

    // ser[WIDTH] is the chain head (wsi), ser[0] the tail (wso).
    logic [WIDTH:0] ser;

    assign op         = decode_op(shift, capture, transfer);
    assign ser[WIDTH] = wsi;
    assign wso        = ser[0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        wbr_cell_sd1 #(
            .RESET_BIT (RESET_VALUE[i]),
            .SAFE_BIT  (SAFE_VALUE[i])
        ) u_cell (
            .wrck      (wrck),
            .arst      (arst),
            .op_i      (op),
            .update_i  (update),
            .si_i      (ser[i+1]),
            .so_o      (ser[i]),
            .cfi_i     (cfi[i]),
            .cfo_o     (cfo[i]),
            .io_face_i (io_face),
            .mode_i    (mode),
            .safe_i    (safe)
        );
    end

endmodule

// File: tb/tb_wbr_segment_sd1.sv
module tb_wbr_segment_sd1;

    logic       wrck = 1'b0;
    logic       arst, wsi, shift, capture, transfer, update, io_face, mode, safe;
    logic       wso;
    logic [3:0] cfi, cfo;

    int n_pass  = 0;
    int n_total = 0;

    wbr_segment_sd1 #(
        .WIDTH       (4),
        .SAFE_VALUE  (4'hA),
        .RESET_VALUE (4'h0)
    ) dut (
        .wrck     (wrck),
        .arst     (arst),
        .wsi      (wsi),
        .wso      (wso),
        .cfi      (cfi),
        .cfo      (cfo),
        .shift    (shift),
        .capture  (capture),
        .transfer (transfer),
        .update   (update),
        .io_face  (io_face),
        .mode     (mode),
        .safe     (safe)
    );

    always #5 wrck = ~wrck;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    typedef struct {
        logic       mode;
        logic       safe;
        logic [3:0] cfi;
        logic [3:0] exp_cfo;
    } cfo_vec_t;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge wrck);
        #1;
    endtask

    task automatic do_shift(input logic b);
        shift = 1'b1;
        wsi   = b;
        cyc();
        shift = 1'b0;
        wsi   = 1'b0;
    endtask

    // v[0] goes in first, so after 4 shifts shift_q == v
    task automatic shift_in4(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            do_shift(v[i]);
    endtask

    // wso is sampled before each shift, so bits appear LSB first
    task automatic shift_out_check(input string name, input logic [3:0] exp);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s bit%0d", name, i), {3'b0, wso}, {3'b0, exp[i]});
            do_shift(1'b0);
        end
    endtask

    task automatic pulse_update();
        update = 1'b1;
        cyc();
        update = 1'b0;
    endtask

    task automatic pulse_capture(input logic face);
        capture = 1'b1;
        io_face = face;
        cyc();
        capture = 1'b0;
    endtask

    cfo_vec_t vecs[5];

    initial begin
        vecs[0] = '{mode: 1'b1, safe: 1'b1, cfi: 4'h5, exp_cfo: 4'hA};
        vecs[1] = '{mode: 1'b1, safe: 1'b0, cfi: 4'hF, exp_cfo: 4'h3};
        vecs[2] = '{mode: 1'b0, safe: 1'b0, cfi: 4'h5, exp_cfo: 4'h5};
        vecs[3] = '{mode: 1'b0, safe: 1'b1, cfi: 4'hC, exp_cfo: 4'hC};
        vecs[4] = '{mode: 1'b1, safe: 1'b1, cfi: 4'h0, exp_cfo: 4'hA};

        arst = 1'b1; wsi = 1'b0; shift = 1'b0; capture = 1'b0; transfer = 1'b0;
        update = 1'b0; io_face = 1'b0; mode = 1'b1; safe = 1'b0; cfi = 4'h9;
        cyc();
        cyc();
        arst = 1'b0;

        check("reset wso", {3'b0, wso}, 4'h0);
        check("reset cfo test", cfo, 4'h0);

        // Load nonzero state, then reset in the middle of a shift cycle.
        shift_in4(4'hF);
        pulse_update();
        check("preload cfo", cfo, 4'hF);
        check("preload wso", {3'b0, wso}, 4'h1);
        shift = 1'b1; wsi = 1'b1;
        #3 arst = 1'b1;
        #1;
        check("midshift arst wso", {3'b0, wso}, 4'h0);
        check("midshift arst cfo", cfo, 4'h0);
        @(posedge wrck);
        #1;
        arst = 1'b0; shift = 1'b0; wsi = 1'b0;
        shift_out_check("post arst shift_q", 4'h0);

        // Shift 1,0,1,1 in; previous (zero) contents emerge first.
        do_shift(1'b1);
        check("s2 wso1", {3'b0, wso}, 4'h0);
        do_shift(1'b0);
        check("s2 wso2", {3'b0, wso}, 4'h0);
        do_shift(1'b1);
        check("s2 wso3", {3'b0, wso}, 4'h0);
        do_shift(1'b1);
        check("s2 wso4", {3'b0, wso}, 4'h1);
        check("s2 cfo before update", cfo, 4'h0);
        pulse_update();
        check("s2 cfo after update", cfo, 4'hD);

        // Capture cfi with io_face=1.
        cfi = 4'h6;
        pulse_capture(1'b1);
        shift_out_check("s3 capture cfi", 4'h6);

        // Transfer upd_q=3 into the shift stage.
        shift_in4(4'h3);
        pulse_update();
        check("s4 upd 3", cfo, 4'h3);
        shift_in4(4'h0);
        transfer = 1'b1;
        cyc();
        transfer = 1'b0;
        shift_out_check("s4 transfer", 4'h3);

        // Shift and capture together: shift wins (shift_q becomes 1000).
        cfi = 4'hF; io_face = 1'b1;
        shift = 1'b1; capture = 1'b1; wsi = 1'b1;
        cyc();
        shift = 1'b0; capture = 1'b0; wsi = 1'b0;
        check("s4 shift beats capture wso", {3'b0, wso}, 4'h0);
        shift_out_check("s4 shift beats capture", 4'h8);

        // Output mux vectors with upd_q still 3.
        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            safe = vecs[i].safe;
            cfi  = vecs[i].cfi;
            #1;
            check($sformatf("cfo vec%0d", i), cfo, vecs[i].exp_cfo);
        end

        // Loopback capture of the safe value.
        mode = 1'b1; safe = 1'b1; cfi = 4'h0;
        pulse_capture(1'b0);
        shift_out_check("s5 capture safe", 4'hA);
        // Loopback capture of upd_q when not safe.
        safe = 1'b0;
        pulse_capture(1'b0);
        shift_out_check("s5 capture upd", 4'h3);

        // Update and shift in the same cycle.
        shift_in4(4'h5);
        update = 1'b1; shift = 1'b1; wsi = 1'b1;
        cyc();
        update = 1'b0; shift = 1'b0; wsi = 1'b0;
        check("s6 upd_q", cfo, 4'h5);
        shift_out_check("s6 shift_q", 4'hA);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
